match_tracker: RTL
==================

MATCH_TRACKER -- requirements
Module: match_tracker

Interface
REQ-001 Parameter ROUNDS, default 9, SHALL set the number of rounds in one match (1..2**CW-1).
REQ-002 Parameter CW, default 4, SHALL set the width of the round and score counters.
REQ-003 Parameter EARLY_FIN, default 1, SHALL enable early match termination once the result is mathematically decided (0 = always play ROUNDS rounds).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 start  input  1  SHALL be a one-cycle request to clear the scores and begin a new match.
REQ-007 round_valid  input  1  SHALL mark round_result valid in the current cycle.
REQ-008 round_result  input  2  SHALL encode 01 = P1 wins, 10 = P2 wins, 11 = draw, 00 = no result.
REQ-009 ready  output  1  SHALL be high when a round result is accepted (state PLAY).
REQ-010 round  output  CW  SHALL be the number of rounds counted in the current match.
REQ-011 win  output  CW  SHALL be the P1 round-win count.
REQ-012 lose  output  CW  SHALL be the P2 round-win count.
REQ-013 fin  output  1  SHALL be high while the match is over (state DONE).
REQ-014 fin_pulse  output  1  SHALL be high for exactly the one cycle in which fin rises.
REQ-015 printwinner  output  2  SHALL encode 10 = P1 ahead/winner, 11 = P2 ahead/winner, 01 = level.

Function
REQ-016 The FSM SHALL have the states IDLE, PLAY and DONE.
REQ-017 start in any state SHALL clear round, win and lose and enter PLAY on the next edge.
REQ-018 When start and round_valid are high together, start SHALL win and the round SHALL be discarded.
REQ-019 In PLAY, round_valid with result 01/10/11 SHALL increment round by 1 on the next edge.
REQ-020 Result 01 SHALL also increment win, result 10 SHALL also increment lose, and result 11 SHALL change no score.
REQ-021 round_valid with result 00, or in IDLE/DONE, SHALL leave all counters unchanged.
REQ-022 The finish condition SHALL be evaluated on the post-update counter values: new round == ROUNDS, or, if EARLY_FIN=1, win > lose + (ROUNDS - round) or lose > win + (ROUNDS - round).
REQ-023 The finish condition SHALL be computed at CW+1 bits so the sum cannot overflow.
REQ-024 On the finish condition, the FSM SHALL enter DONE on the same edge that updates the counters (latency 1 cycle from the accepted round_valid to fin).
REQ-025 DONE SHALL hold all counters until start or rst.
REQ-026 printwinner SHALL be a combinational comparison of the registered win and lose, valid in every state.
REQ-027 ready SHALL equal (state == PLAY).
REQ-028 Counters SHALL never wrap, because DONE is entered no later than round == ROUNDS.

Reset
REQ-029 rst SHALL force state IDLE, round = win = lose = 0, fin = 0, fin_pulse = 0, ready = 0, and printwinner = 01.
REQ-030 rst asserted mid-match SHALL discard the match immediately, with no fin_pulse.
REQ-031 After rst deasserts, the block SHALL stay in IDLE until start.

Structure
REQ-032 Package match_pkg SHALL hold the round_result encodings, the printwinner encodings and the FSM state type.
REQ-033 One sub-module, score_cmp (a CW-parametrised magnitude comparator producing the printwinner encoding), SHALL be instantiated for printwinner.
REQ-034 An elaboration check SHALL reject ROUNDS == 0 or ROUNDS >= 2**CW.

Verification (ROUNDS=9, CW=4)
REQ-035 Reset check: start, 3 P1 wins, then rst pulse -> round = win = lose = 0, IDLE, printwinner = 01, fin_pulse never asserted.
REQ-036 EARLY_FIN=1 check: start, 5 consecutive 01 results -> fin and fin_pulse rise one cycle after the 5th result, with round = 5, win = 5, printwinner = 10; a further 01 leaves win = 5.
REQ-037 EARLY_FIN=0 check: the same stimulus plus 4 results of 10 -> fin rises only after the 9th result, with win = 5, lose = 4, printwinner = 10.
REQ-038 Level match check: 4×01, 4×10, 1×11 -> fin after the 9th result, with round = 9, win = 4, lose = 4, printwinner = 01.
REQ-039 Restart check: in DONE, start together with round_valid/01 -> next cycle PLAY, round = win = lose = 0, fin = 0.
REQ-040 Ignored-input check: in PLAY, round_valid with 00 for 3 cycles -> all counters unchanged, ready stays 1.

Source files
------------

// File: rtl/match_pkg.sv
// Shared encodings for the match tracker: round results, winner code
// and the match FSM state type.
package match_pkg;

    // round_result encodings
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    // printwinner encodings
    localparam logic [1:0] PW_LEVEL = 2'b01;
    localparam logic [1:0] PW_P1    = 2'b10;
    localparam logic [1:0] PW_P2    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/match_tracker_score_cmp.sv
// Magnitude comparator turning the two round-win counts into the
// printwinner code (P1 ahead, P2 ahead, or level).
module score_cmp
    import match_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    output logic [1:0]    o_code
);

    // Compare P1 count (i_a) against P2 count (i_b).
    always_comb begin
        o_code = PW_LEVEL;
        if (i_a > i_b) begin
            o_code = PW_P1;
        end else if (i_b > i_a) begin
            o_code = PW_P2;
        end
    end

endmodule

// File: rtl/match_tracker.sv
// Match tracker: counts rounds and per-player wins for one match, ends
// the match after ROUNDS rounds or, optionally, as soon as the outcome
// can no longer change, and reports the current leader.
module match_tracker
    import match_pkg::*;
#(
    parameter int ROUNDS    = 9,
    parameter int CW        = 4,
    parameter int EARLY_FIN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          round_valid,
    input  logic [1:0]    round_result,
    output logic          ready,
    output logic [CW-1:0] round,
    output logic [CW-1:0] win,
    output logic [CW-1:0] lose,
    output logic          fin,
    output logic          fin_pulse,
    output logic [1:0]    printwinner
);

    generate
        if (ROUNDS < 1 || ROUNDS >= (2 ** CW)) begin : g_bad_rounds
            $error("match_tracker: ROUNDS must lie in 1 .. 2**CW-1");
        end
    endgenerate

    // One extra bit so win + remaining rounds can never overflow.
    localparam logic [CW:0] L_ROUNDS = (CW+1)'(ROUNDS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_round;
    logic [CW-1:0]   r_win;
    logic [CW-1:0]   r_lose;
    logic            r_fin_pulse;

    logic            w_accept;
    logic [CW-1:0]   w_round_nxt;
    logic [CW-1:0]   w_win_nxt;
    logic [CW-1:0]   w_lose_nxt;
    logic            w_fin_pulse_nxt;
    logic [CW:0]     w_round_e;
    logic [CW:0]     w_win_e;
    logic [CW:0]     w_lose_e;
    logic [CW:0]     w_left;
    logic            w_finish;

    // A round counts only in PLAY, with a real result, and when no restart
    // request competes with it in the same cycle.
    assign w_accept = (r_state == ST_PLAY) && round_valid &&
                      (round_result != RES_NONE) && !start;

    // Next counter values: restart clears, an accepted round scores.
    always_comb begin
        w_round_nxt = r_round;
        w_win_nxt   = r_win;
        w_lose_nxt  = r_lose;
        if (start) begin
            w_round_nxt = '0;
            w_win_nxt   = '0;
            w_lose_nxt  = '0;
        end else if (w_accept) begin
            w_round_nxt = r_round + 1'b1;
            case (round_result)
                RES_P1:  w_win_nxt  = r_win + 1'b1;
                RES_P2:  w_lose_nxt = r_lose + 1'b1;
                default: ;
            endcase
        end
    end

    // Finish test on the post-update counts, widened by one bit.
    always_comb begin
        w_round_e = {1'b0, w_round_nxt};
        w_win_e   = {1'b0, w_win_nxt};
        w_lose_e  = {1'b0, w_lose_nxt};
        w_left    = L_ROUNDS - w_round_e;
        w_finish  = (w_round_e == L_ROUNDS);
        if (EARLY_FIN != 0) begin
            if ((w_win_e > (w_lose_e + w_left)) || (w_lose_e > (w_win_e + w_left))) begin
                w_finish = 1'b1;
            end
        end
    end

    // Next FSM state, plus the one-shot flag for entering DONE.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_PLAY;
        end else if (w_accept && w_finish) begin
            w_state_nxt = ST_DONE;
        end
        w_fin_pulse_nxt = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
    end

    // State, counters and fin pulse register; reset abandons any match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_round     <= '0;
            r_win       <= '0;
            r_lose      <= '0;
            r_fin_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_round     <= w_round_nxt;
            r_win       <= w_win_nxt;
            r_lose      <= w_lose_nxt;
            r_fin_pulse <= w_fin_pulse_nxt;
        end
    end

    score_cmp #(
        .CW (CW)
    ) u_score_cmp (
        .i_a    (r_win),
        .i_b    (r_lose),
        .o_code (printwinner)
    );

    assign ready     = (r_state == ST_PLAY);
    assign fin       = (r_state == ST_DONE);
    assign fin_pulse = r_fin_pulse;
    assign round     = r_round;
    assign win       = r_win;
    assign lose      = r_lose;

endmodule
